// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle controller: opcodes, FSM states, field positions, write-data selects.
package cpu_pkg;

    localparam int INSTR_W = 12;

    localparam int OP_MSB  = 11;
    localparam int OP_LSB  = 9;
    localparam int RD_MSB  = 8;
    localparam int RD_LSB  = 6;
    localparam int RS1_MSB = 5;
    localparam int RS1_LSB = 3;
    localparam int RS2_MSB = 2;
    localparam int RS2_LSB = 0;
    localparam int IMM_MSB = 3;
    localparam int IMM_LSB = 0;

    typedef enum logic [2:0] {
        OP_LOAD  = 3'b000,
        OP_STORE = 3'b001,
        OP_ADD   = 3'b010,
        OP_SUB   = 3'b011,
        OP_LDI   = 3'b100,
        OP_NOP5  = 3'b101,
        OP_NOP6  = 3'b110,
        OP_HALT  = 3'b111
    } opcode_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [1:0] WD_ALU = 2'd0;
    localparam logic [1:0] WD_DM  = 2'd1;
    localparam logic [1:0] WD_IMM = 2'd2;

endpackage

// File: rtl/inst_decode.sv
// Splits an instruction word into its fields and classifies what it writes.
// Latency: purely combinational.
// Backpressure: none; follows the instruction register directly.
module inst_decode
    import cpu_pkg::*;
(
    input  logic [INSTR_W-1:0] ir,
    output opcode_t            op,
    output logic [2:0]         rd,
    output logic [2:0]         rs1,
    output logic [2:0]         rs2,
    output logic [3:0]         addr,
    output logic [3:0]         imm,
    output logic               writes_rf,
    output logic               writes_dm,
    output logic               is_halt
);

    assign op   = opcode_t'(ir[OP_MSB:OP_LSB]);
    assign rd   = ir[RD_MSB:RD_LSB];
    assign rs1  = ir[RS1_MSB:RS1_LSB];
    assign rs2  = ir[RS2_MSB:RS2_LSB];
    assign addr = ir[IMM_MSB:IMM_LSB];
    assign imm  = ir[IMM_MSB:IMM_LSB];

    assign writes_rf = (op == OP_LOAD) || (op == OP_ADD) || (op == OP_SUB) || (op == OP_LDI);
    assign writes_dm = (op == OP_STORE);
    assign is_halt   = (op == OP_HALT);

endmodule

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/exec/writeback controller driving register file, ALU and data memory.
// Latency: 4 cycles per instruction (HALT reaches HALT state 2 cycles after its fetch).
// Backpressure: none; start is only honoured in IDLE/HALT and ignored while busy.
module control_unit
    import cpu_pkg::*;
#(
    parameter int PC_W = 4,
    parameter int IW   = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [PC_W-1:0] IM_addr,
    input  logic [IW-1:0]   IM_data,
    output logic [2:0]      RF_ad1,
    output logic [2:0]      RF_ad2,
    output logic [2:0]      RF_wa,
    output logic            RF_we,
    output logic [1:0]      WD_sel,
    output logic [3:0]      IMM,
    output logic            ALU_op,
    output logic [3:0]      DM_addr,
    output logic            DM_we,
    output logic            busy,
    output logic            halted
);

    state_t          state;
    state_t          state_nxt;
    logic [PC_W-1:0] pc;
    logic [IW-1:0]   ir;

    opcode_t    op;
    logic [2:0] rd;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic [3:0] addr;
    logic [3:0] imm;
    logic       writes_rf;
    logic       writes_dm;
    logic       is_halt;

    inst_decode u_dec (
        .ir        (ir),
        .op        (op),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .addr      (addr),
        .imm       (imm),
        .writes_rf (writes_rf),
        .writes_dm (writes_dm),
        .is_halt   (is_halt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            pc    <= '0;
            ir    <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_FETCH) begin
                ir <= IM_data;
                pc <= pc + PC_W'(1);
            end else if (state == S_HALT && start) begin
                pc <= '0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        RF_ad1    = 3'd0;
        RF_ad2    = 3'd0;
        RF_wa     = 3'd0;
        RF_we     = 1'b0;
        WD_sel    = WD_ALU;
        IMM       = 4'd0;
        ALU_op    = 1'b0;
        DM_addr   = 4'd0;
        DM_we     = 1'b0;

        case (state)
            S_IDLE:   if (start) state_nxt = S_FETCH;
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: state_nxt = is_halt ? S_HALT : S_EXEC;
            S_EXEC:   state_nxt = S_WB;
            S_WB:     state_nxt = S_FETCH;
            S_HALT:   if (start) state_nxt = S_FETCH;
            default:  state_nxt = S_IDLE;
        endcase

        if (state == S_DECODE || state == S_EXEC || state == S_WB) begin
            RF_ad1  = rs1;
            RF_ad2  = rs2;
            RF_wa   = rd;
            DM_addr = addr;
            IMM     = imm;
            ALU_op  = (op == OP_SUB);
            if (op == OP_LOAD)
                WD_sel = WD_DM;
            else if (op == OP_LDI)
                WD_sel = WD_IMM;
        end

        // Strobes are masked by rst so an aborted WB never commits a write.
        if (state == S_WB && !rst) begin
            RF_we = writes_rf;
            DM_we = writes_dm;
        end
    end

    assign IM_addr = pc;
    assign busy    = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXEC) || (state == S_WB);
    assign halted  = (state == S_HALT);

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: an instruction-level model checked every cycle plus literal spot checks.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  IM_addr;
    logic [11:0] IM_data;
    logic [2:0]  RF_ad1, RF_ad2, RF_wa;
    logic        RF_we;
    logic [1:0]  WD_sel;
    logic [3:0]  IMM;
    logic        ALU_op;
    logic [3:0]  DM_addr;
    logic        DM_we;
    logic        busy, halted;

    logic [11:0] imem [16];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign IM_data = imem[IM_addr];

    control_unit #(.PC_W(4), .IW(12)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .IM_addr (IM_addr),
        .IM_data (IM_data),
        .RF_ad1  (RF_ad1),
        .RF_ad2  (RF_ad2),
        .RF_wa   (RF_wa),
        .RF_we   (RF_we),
        .WD_sel  (WD_sel),
        .IMM     (IMM),
        .ALU_op  (ALU_op),
        .DM_addr (DM_addr),
        .DM_we   (DM_we),
        .busy    (busy),
        .halted  (halted)
    );

    // Model: run mode (0 idle, 1 running, 2 halted), program counter, current instruction,
    // and the cycle index within the instruction (0 fetch .. 3 writeback).
    int          m_run = 0;
    int          m_ph  = 0;
    logic [3:0]  m_pc  = 4'd0;
    logic [11:0] m_ir  = 12'd0;
    bit          m_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_run = 0; m_ph = 0; m_pc = 4'd0; m_ir = 12'd0; m_valid = 1'b1;
        end else if (m_run == 0) begin
            if (start) begin m_run = 1; m_ph = 0; end
        end else if (m_run == 2) begin
            if (start) begin m_run = 1; m_ph = 0; m_pc = 4'd0; end
        end else begin
            if (m_ph == 0) begin
                m_ir = imem[m_pc];
                m_pc = 4'((m_pc + 1) % 16);
                m_ph = 1;
            end else if (m_ph == 1 && m_ir[11:9] == 3'd7) begin
                m_run = 2;
            end else begin
                m_ph = (m_ph + 1) % 4;
            end
        end
    end

    function automatic logic [27:0] exp_out();
        logic [2:0] op;
        bit         act;
        bit         wb;
        logic [2:0] a1, a2, wa;
        logic [3:0] im;
        logic [1:0] wd;
        logic       alu, rwe, dwe;
        op  = m_ir[11:9];
        act = (m_run == 1) && (m_ph != 0);
        wb  = (m_run == 1) && (m_ph == 3) && !rst;
        a1  = act ? m_ir[5:3] : 3'd0;
        a2  = act ? m_ir[2:0] : 3'd0;
        wa  = act ? m_ir[8:6] : 3'd0;
        im  = act ? m_ir[3:0] : 4'd0;
        alu = act && (op == 3'd3);
        wd  = !act ? 2'd0 : (op == 3'd0) ? 2'd1 : (op == 3'd4) ? 2'd2 : 2'd0;
        rwe = wb && (op == 3'd0 || op == 3'd2 || op == 3'd3 || op == 3'd4);
        dwe = wb && (op == 3'd1);
        return {m_pc, a1, a2, wa, rwe, wd, im, alu, im, dwe, 1'(m_run == 1), 1'(m_run == 2)};
    endfunction

    always @(negedge clk) begin
        if (m_valid) begin
            logic [27:0] got;
            logic [27:0] exp;
            got = {IM_addr, RF_ad1, RF_ad2, RF_wa, RF_we, WD_sel, IMM, ALU_op, DM_addr, DM_we, busy, halted};
            exp = exp_out();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL cycle_outputs t=%0t got=%h expected=%h", $time, got, exp);
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 16; i++) imem[i] = 12'hA00;

        // Reset and idle
        tick(); tick();
        chk("rst_im_addr", IM_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_rf_we", RF_we, 0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_im_addr", IM_addr, 0);
            chk("idle_busy", busy, 0);
        end

        // LDI r3,5 then HALT
        imem[0] = 12'h8C5;
        imem[1] = 12'hE00;
        start = 1'b1; tick(); start = 1'b0;
        chk("ldi_fetch_busy", busy, 1);
        chk("ldi_fetch_addr", IM_addr, 0);
        tick();
        chk("ldi_decode_addr", IM_addr, 1);
        tick(); tick();
        chk("ldi_wb_we", RF_we, 1);
        chk("ldi_wb_wa", RF_wa, 3);
        chk("ldi_wb_wdsel", WD_sel, 2);
        chk("ldi_wb_imm", IMM, 5);
        tick();
        chk("ldi_after_we", RF_we, 0);
        tick(); tick();
        chk("ldi_halted", halted, 1);
        chk("ldi_halt_busy", busy, 0);

        // ADD r1,r2,r3 ; SUB r4,r5,r6 ; HALT
        imem[0] = 12'h453;
        imem[1] = 12'h72E;
        imem[2] = 12'hE00;
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 2; c <= 11; c++) begin
            tick();
            if (c == 2) begin
                chk("add_ad1", RF_ad1, 2); chk("add_ad2", RF_ad2, 3); chk("add_alu", ALU_op, 0);
            end
            if (c == 4) begin chk("add_we", RF_we, 1); chk("add_wa", RF_wa, 1); end
            if (c == 6) begin
                chk("sub_ad1", RF_ad1, 5); chk("sub_ad2", RF_ad2, 6); chk("sub_alu", ALU_op, 1);
            end
            if (c == 8) begin chk("sub_we", RF_we, 1); chk("sub_wa", RF_wa, 4); end
            if (c == 11) chk("addsub_halted", halted, 1);
        end

        // STORE r7 -> DM[9] ; LOAD r2 <- DM[9] ; HALT
        imem[0] = 12'h239;
        imem[1] = 12'h089;
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 2; c <= 11; c++) begin
            tick();
            if (c == 4) begin
                chk("st_dm_we", DM_we, 1); chk("st_dm_addr", DM_addr, 9);
                chk("st_ad1", RF_ad1, 7); chk("st_rf_we", RF_we, 0);
            end
            if (c == 8) begin
                chk("ld_rf_we", RF_we, 1); chk("ld_wdsel", WD_sel, 1);
                chk("ld_wa", RF_wa, 2); chk("ld_dm_we", DM_we, 0);
            end
            if (c == 9) chk("halt_fetch_addr", IM_addr, 2);
            if (c == 10) chk("halt_decode_halted", halted, 0);
            if (c == 11) begin
                chk("halt_halted", halted, 1); chk("halt_rf_we", RF_we, 0); chk("halt_dm_we", DM_we, 0);
            end
        end

        // Restart from HALT with start held high: the program loops back through HALT
        start = 1'b1; tick();
        chk("restart_addr", IM_addr, 0);
        chk("restart_busy", busy, 1);
        chk("restart_halted", halted, 0);
        for (int c = 2; c <= 12; c++) begin
            tick();
            if (c == 11) chk("loop_halted", halted, 1);
            if (c == 12) begin chk("loop_refetch_addr", IM_addr, 0); chk("loop_busy", busy, 1); end
        end
        start = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst2_busy", busy, 0);

        // PC wrap over 16 NOPs; start held high throughout is ignored while running
        for (int i = 0; i < 16; i++) imem[i] = 12'hA00;
        start = 1'b1; tick();
        for (int i = 0; i <= 16; i++) begin
            chk("wrap_fetch_addr", IM_addr, i % 16);
            tick(); tick(); tick(); tick();
        end
        chk("wrap_not_halted", halted, 0);
        start = 1'b0;

        // Reset during EXEC of ADD
        rst = 1'b1; tick(); rst = 1'b0;
        imem[0] = 12'h453;
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        chk("midrst_exec_busy", busy, 1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_addr", IM_addr, 0);
        chk("midrst_rf_we", RF_we, 0);
        chk("midrst_halted", halted, 0);

        // Reset landing in WB must suppress the write in that same cycle
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick(); tick();
        chk("wbrst_pre_we", RF_we, 1);
        rst = 1'b1; #1;
        chk("wbrst_we_masked", RF_we, 0);
        tick(); rst = 1'b0;
        tick();
        chk("wbrst_after_we", RF_we, 0);
        chk("wbrst_after_busy", busy, 0);

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
